// File: rtl/cv32e40p_alu_spare_ctrl.sv
// ---------------------------------------------------------------------------
// cv32e40p_alu_spare_ctrl
//
// Hot-spare controller for a four-ALU voted execution stage. Three ALUs feed
// the voters while the fourth (off_idx) is unclocked and held in reserve.
// Each active ALU has a saturating error counter. When a counter reaches
// THRESHOLD the ALU is flagged permanently faulty. The spare is then brought
// in by a drain / warm-up / switch sequence that stalls EX issue. A second
// fault, or two simultaneous faults, leaves the block in an absorbing
// DEGRADED state.
//
// Optional feature macro: CV32E40P_ALU_SPARE_DECAY_EN
//   When defined, every DECAY_WINDOW valid operations each nonzero,
//   non-faulty counter is decremented by one, so sporadic soft errors age out.
//   When undefined, counters only count up and no window counter is built.
//
// Parameters
//   THRESHOLD    error count (1..255) that declares an active ALU faulty
//   DECAY_WINDOW valid-op count per decay step (power of 2, >= 2)
//   WARMUP_CYC   cycles (>= 1) the incoming spare is clocked before use
//
// Ports
//   clk            clock; all state updates on its rising edge
//   rst_n          asynchronous active-low reset
//   op_valid_i     one ALU operation is voted this cycle
//   err_detected_i per-ALU voter mismatch, qualified by op_valid_i
//   ex_idle_i      no ALU operation in flight
//   clock_en_o     per-ALU input-register clock enable
//   sel_mux_o      bit k=1 routes ALU k to voter k, bit k=0 routes ALU3
//   stall_o        hold EX issue during reconfiguration
//   faulty_o       sticky per-ALU permanent-fault flags
//   fault_event_o  one-cycle pulse per newly faulty ALU
//   degraded_o     sticky; no healthy spare remains
// ---------------------------------------------------------------------------
module cv32e40p_alu_spare_ctrl #(
    parameter int unsigned THRESHOLD    = 8,
    parameter int unsigned DECAY_WINDOW = 256,
    parameter int unsigned WARMUP_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid_i,
    input  logic [3:0] err_detected_i,
    input  logic       ex_idle_i,
    output logic [3:0] clock_en_o,
    output logic [2:0] sel_mux_o,
    output logic       stall_o,
    output logic [3:0] faulty_o,
    output logic [3:0] fault_event_o,
    output logic       degraded_o
);

    // Elaboration-time parameter sanity checks.
    if (THRESHOLD < 1 || THRESHOLD > 255) begin : g_chk_threshold
        $error("THRESHOLD must be in 1..255");
    end
    if (DECAY_WINDOW < 2 || (DECAY_WINDOW & (DECAY_WINDOW - 1)) != 0) begin : g_chk_decay
        $error("DECAY_WINDOW must be a power of two >= 2");
    end
    if (WARMUP_CYC < 1) begin : g_chk_warmup
        $error("WARMUP_CYC must be >= 1");
    end

    localparam int unsigned WW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam logic [7:0]    THR_M1    = 8'(THRESHOLD - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);

    typedef enum logic [2:0] {
        ST_NORMAL,
        ST_DRAIN,
        ST_WARMUP,
        ST_SWITCH,
        ST_DEGRADED
    } state_e;

    state_e        state_q, state_n;
    logic [1:0]    off_q, off_n;
    logic [1:0]    target_q, target_n;
    logic [WW-1:0] warm_q, warm_n;
    logic          late_q, late_n;
    logic [7:0]    cnt_q [4];
    logic [7:0]    cnt_n [4];
    logic [3:0]    faulty_q;

    logic          counting;
    logic          wrap;
    logic [3:0]    inc;
    logic [3:0]    dec;
    logic [3:0]    new_fault;
    logic          multi_fault;
    logic [1:0]    fault_idx;

    logic [3:0]    clock_en_n;
    logic [2:0]    sel_mux_n;
    logic          stall_n;
    logic          degraded_n;

    // Counters and window are frozen once degraded.
    assign counting = (state_q != ST_DEGRADED);
    assign faulty_o = faulty_q;

`ifdef CV32E40P_ALU_SPARE_DECAY_EN
    localparam int unsigned WIN_W = $clog2(DECAY_WINDOW);
    logic [WIN_W-1:0] win_q;

    // The window wraps on the valid op that completes DECAY_WINDOW ops.
    assign wrap = counting && op_valid_i && (&win_q);
`else
    assign wrap = 1'b0;
`endif

    // Per-ALU counter update. An increment and a decay decrement landing in
    // the same cycle cancel, so a fault can only be declared by a net
    // increment that lands exactly on THRESHOLD.
    always_comb begin
        inc       = '0;
        dec       = '0;
        new_fault = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_n[i] = cnt_q[i];
            inc[i] = counting && op_valid_i && err_detected_i[i] &&
                     (off_q != 2'(i)) && !faulty_q[i] && (cnt_q[i] != 8'hFF);
            dec[i] = wrap && (cnt_q[i] != 8'h00) && !faulty_q[i];
            if (inc[i] && !dec[i]) begin
                cnt_n[i]     = cnt_q[i] + 8'd1;
                new_fault[i] = (cnt_q[i] == THR_M1);
            end else if (dec[i] && !inc[i]) begin
                cnt_n[i] = cnt_q[i] - 8'd1;
            end
        end
    end

    // Index of the (single) newly faulty ALU, and detection of several
    // faults arriving together.
    always_comb begin
        fault_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (new_fault[i]) begin
                fault_idx = 2'(i);
            end
        end
    end
    assign multi_fault = |(new_fault & (new_fault - 4'd1));

    // Reconfiguration sequencing. A fault seen while already reconfiguring
    // is remembered in late_q; the swap still completes but the block then
    // parks in DEGRADED because no healthy spare is left.
    always_comb begin
        state_n  = state_q;
        off_n    = off_q;
        target_n = target_q;
        warm_n   = warm_q;
        late_n   = late_q;
        unique case (state_q)
            ST_NORMAL: begin
                if (|new_fault) begin
                    if (multi_fault || (|faulty_q)) begin
                        state_n = ST_DEGRADED;
                    end else begin
                        state_n  = ST_DRAIN;
                        target_n = fault_idx;
                        late_n   = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (|new_fault) late_n = 1'b1;
                if (ex_idle_i) begin
                    state_n = ST_WARMUP;
                    warm_n  = '0;
                end
            end
            ST_WARMUP: begin
                if (|new_fault) late_n = 1'b1;
                if (warm_q == WARM_LAST) begin
                    state_n = ST_SWITCH;
                end else begin
                    warm_n = warm_q + WW'(1);
                end
            end
            ST_SWITCH: begin
                off_n   = target_q;
                state_n = (late_q || (|new_fault)) ? ST_DEGRADED : ST_NORMAL;
                late_n  = 1'b0;
            end
            ST_DEGRADED: begin
                state_n = ST_DEGRADED;
            end
            default: begin
                state_n = ST_NORMAL;
            end
        endcase
    end

    // Output values for the next cycle, registered below. During warm-up all
    // four ALUs are clocked so the incoming spare settles before selection.
    always_comb begin
        stall_n    = (state_n == ST_DRAIN) || (state_n == ST_WARMUP) ||
                     (state_n == ST_SWITCH);
        degraded_n = (state_n == ST_DEGRADED);
        clock_en_n = (state_n == ST_WARMUP) ? 4'hF : ~(4'b0001 << off_n);
        for (int k = 0; k < 3; k++) begin
            sel_mux_n[k] = (off_n != 2'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_NORMAL;
            off_q         <= 2'd3;
            target_q      <= 2'd3;
            warm_q        <= '0;
            late_q        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
            faulty_q      <= 4'b0000;
            fault_event_o <= 4'b0000;
            clock_en_o    <= 4'b0111;
            sel_mux_o     <= 3'b111;
            stall_o       <= 1'b0;
            degraded_o    <= 1'b0;
`ifdef CV32E40P_ALU_SPARE_DECAY_EN
            win_q         <= '0;
`endif
        end else begin
            state_q       <= state_n;
            off_q         <= off_n;
            target_q      <= target_n;
            warm_q        <= warm_n;
            late_q        <= late_n;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_n[i];
            end
            faulty_q      <= faulty_q | new_fault;
            fault_event_o <= new_fault;
            clock_en_o    <= clock_en_n;
            sel_mux_o     <= sel_mux_n;
            stall_o       <= stall_n;
            degraded_o    <= degraded_n;
`ifdef CV32E40P_ALU_SPARE_DECAY_EN
            if (counting && op_valid_i) begin
                win_q <= win_q + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cv32e40p_alu_spare_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_alu_spare_ctrl
//
// Self-checking bench for cv32e40p_alu_spare_ctrl with THRESHOLD=4,
// DECAY_WINDOW=256, WARMUP_CYC=2. Directed scenarios are checked against
// literal expected values; a randomized run is checked cycle by cycle
// against a behavioural model of the spare-swap policy.
// ---------------------------------------------------------------------------
module tb_cv32e40p_alu_spare_ctrl;

    localparam int THR = 4;
    localparam int DW  = 256;
    localparam int WC  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid_i;
    logic [3:0] err_detected_i;
    logic       ex_idle_i;
    logic [3:0] clock_en_o;
    logic [2:0] sel_mux_o;
    logic       stall_o;
    logic [3:0] faulty_o;
    logic [3:0] fault_event_o;
    logic       degraded_o;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: mode 0 = running, 1 = reconfiguring, 2 = degraded.
    // phase counts progress through a reconfiguration: 0 waits for idle,
    // 1..WC are warm-up cycles, WC+1 is the switch cycle.
    int       m_cnt [4];
    bit [3:0] m_faulty;
    bit [3:0] m_event;
    int       m_off;
    int       m_mode;
    int       m_phase;
    int       m_target;
    bit       m_late;
    int       m_ops;

    cv32e40p_alu_spare_ctrl #(
        .THRESHOLD   (THR),
        .DECAY_WINDOW(DW),
        .WARMUP_CYC  (WC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid_i    (op_valid_i),
        .err_detected_i(err_detected_i),
        .ex_idle_i     (ex_idle_i),
        .clock_en_o    (clock_en_o),
        .sel_mux_o     (sel_mux_o),
        .stall_o       (stall_o),
        .faulty_o      (faulty_o),
        .fault_event_o (fault_event_o),
        .degraded_o    (degraded_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_faulty = 4'b0000;
        m_event  = 4'b0000;
        m_off    = 3;
        m_mode   = 0;
        m_phase  = 0;
        m_target = 3;
        m_late   = 1'b0;
        m_ops    = 0;
    endtask

    task automatic model_step(input bit op, input bit [3:0] err, input bit idle);
        bit [3:0] nf;
        bit       wrapped;
        bit       prior;
        bit       inc;
        bit       dec;
        nf      = 4'b0000;
        m_event = 4'b0000;
        if (m_mode == 2) return;
        wrapped = 1'b0;
        if (op) begin
            m_ops++;
`ifdef CV32E40P_ALU_SPARE_DECAY_EN
            wrapped = ((m_ops % DW) == 0);
`endif
        end
        for (int i = 0; i < 4; i++) begin
            inc = op && err[i] && (i != m_off) && !m_faulty[i];
            dec = wrapped && (m_cnt[i] > 0) && !m_faulty[i];
            if (inc && !dec) begin
                if (m_cnt[i] < 255) m_cnt[i]++;
                if (m_cnt[i] == THR) nf[i] = 1'b1;
            end else if (dec && !inc) begin
                m_cnt[i]--;
            end
        end
        prior    = (m_faulty != 4'b0000);
        m_faulty = m_faulty | nf;
        m_event  = nf;
        if (m_mode == 0) begin
            if ($countones(nf) >= 2 || ($countones(nf) == 1 && prior)) begin
                m_mode = 2;
            end else if ($countones(nf) == 1) begin
                m_mode  = 1;
                m_phase = 0;
                m_late  = 1'b0;
                for (int i = 0; i < 4; i++) if (nf[i]) m_target = i;
            end
        end else begin
            if (nf != 4'b0000) m_late = 1'b1;
            if (m_phase == 0) begin
                if (idle) m_phase = 1;
            end else if (m_phase <= WC) begin
                m_phase++;
            end else begin
                m_off  = m_target;
                m_mode = m_late ? 2 : 0;
            end
        end
    endtask

    task automatic step(input bit op, input bit [3:0] err, input bit idle);
        op_valid_i     = op;
        err_detected_i = err;
        ex_idle_i      = idle;
        model_step(op, err, idle);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        op_valid_i     = 1'b0;
        err_detected_i = 4'b0000;
        ex_idle_i      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (clock_en_o !== 4'b0111) begin miscompares++; $display("[TB] FAIL reset_clock_en got %b exp 0111", clock_en_o); end
        vectors++; if (sel_mux_o !== 3'b111) begin miscompares++; $display("[TB] FAIL reset_sel_mux got %b exp 111", sel_mux_o); end
        vectors++; if (faulty_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_faulty got %b exp 0000", faulty_o); end
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got %b exp 0", stall_o); end
        vectors++; if (degraded_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_degraded got %b exp 0", degraded_o); end
        vectors++; if (fault_event_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_event got %b exp 0000", fault_event_o); end
    endtask

    task automatic test_single_fault();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            step(1'b1, 4'b0010, 1'b1);
            vectors++; if (stall_o !== 1'b0 || fault_event_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL pre_fault op %0d got stall %b event %b exp 0 0000", n, stall_o, fault_event_o); end
        end
        step(1'b1, 4'b0010, 1'b1);
        vectors++; if (fault_event_o !== 4'b0010) begin miscompares++; $display("[TB] FAIL fault_event got %b exp 0010", fault_event_o); end
        vectors++; if (faulty_o !== 4'b0010) begin miscompares++; $display("[TB] FAIL fault_flag got %b exp 0010", faulty_o); end
        vectors++; if (stall_o !== 1'b1 || clock_en_o !== 4'b0111) begin miscompares++; $display("[TB] FAIL drain got stall %b clk_en %b exp 1 0111", stall_o, clock_en_o); end
        for (int n = 0; n < WC; n++) begin
            step(1'b0, 4'b0000, 1'b1);
            vectors++; if (stall_o !== 1'b1 || clock_en_o !== 4'b1111 || sel_mux_o !== 3'b111) begin miscompares++; $display("[TB] FAIL warmup %0d got stall %b clk_en %b sel %b exp 1 1111 111", n, stall_o, clock_en_o, sel_mux_o); end
            vectors++; if (fault_event_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL event_width got %b exp 0000", fault_event_o); end
        end
        step(1'b0, 4'b0000, 1'b1);
        vectors++; if (stall_o !== 1'b1 || clock_en_o !== 4'b0111 || sel_mux_o !== 3'b111) begin miscompares++; $display("[TB] FAIL switch got stall %b clk_en %b sel %b exp 1 0111 111", stall_o, clock_en_o, sel_mux_o); end
        step(1'b0, 4'b0000, 1'b1);
        vectors++; if (stall_o !== 1'b0 || clock_en_o !== 4'b1101 || sel_mux_o !== 3'b101) begin miscompares++; $display("[TB] FAIL swapped got stall %b clk_en %b sel %b exp 0 1101 101", stall_o, clock_en_o, sel_mux_o); end
        vectors++; if (degraded_o !== 1'b0) begin miscompares++; $display("[TB] FAIL swapped_degraded got %b exp 0", degraded_o); end
    endtask

    // Continues from the swapped configuration left by test_single_fault.
    task automatic test_second_fault();
        for (int n = 0; n < THR; n++) step(1'b1, 4'b0001, 1'b1);
        vectors++; if (faulty_o !== 4'b0011) begin miscompares++; $display("[TB] FAIL second_faulty got %b exp 0011", faulty_o); end
        vectors++; if (degraded_o !== 1'b1 || stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL second_degraded got deg %b stall %b exp 1 0", degraded_o, stall_o); end
        vectors++; if (fault_event_o !== 4'b0001) begin miscompares++; $display("[TB] FAIL second_event got %b exp 0001", fault_event_o); end
        step(1'b1, 4'b1100, 1'b1);
        vectors++; if (sel_mux_o !== 3'b101 || clock_en_o !== 4'b1101 || degraded_o !== 1'b1) begin miscompares++; $display("[TB] FAIL degraded_frozen got sel %b clk_en %b deg %b exp 101 1101 1", sel_mux_o, clock_en_o, degraded_o); end
        vectors++; if (fault_event_o !== 4'b0000 || faulty_o !== 4'b0011) begin miscompares++; $display("[TB] FAIL degraded_no_count got event %b faulty %b exp 0000 0011", fault_event_o, faulty_o); end
    endtask

    task automatic test_spare_ignored();
        do_reset();
        for (int n = 0; n < 10; n++) step(1'b1, 4'b1000, 1'b1);
        vectors++; if (faulty_o !== 4'b0000 || stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL spare_ignored got faulty %b stall %b exp 0000 0", faulty_o, stall_o); end
        for (int n = 0; n < 10; n++) step(1'b0, 4'b0111, 1'b1);
        vectors++; if (faulty_o !== 4'b0000 || stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL unqualified_ignored got faulty %b stall %b exp 0000 0", faulty_o, stall_o); end
    endtask

    task automatic test_decay();
        logic [3:0] exp_f;
`ifdef CV32E40P_ALU_SPARE_DECAY_EN
        exp_f = 4'b0000;
`else
        exp_f = 4'b0100;
`endif
        do_reset();
        for (int n = 0; n < 3; n++) step(1'b1, 4'b0100, 1'b1);
        for (int n = 0; n < DW; n++) step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0100, 1'b1);
        vectors++; if (faulty_o !== exp_f) begin miscompares++; $display("[TB] FAIL decay got %b exp %b", faulty_o, exp_f); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int n = 0; n < THR; n++) step(1'b1, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_hold got %b exp 1", stall_o); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (clock_en_o !== 4'b0111 || sel_mux_o !== 3'b111) begin miscompares++; $display("[TB] FAIL async_reset_cfg got clk_en %b sel %b exp 0111 111", clock_en_o, sel_mux_o); end
        vectors++; if (faulty_o !== 4'b0000 || stall_o !== 1'b0 || degraded_o !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_flags got faulty %b stall %b deg %b exp 0000 0 0", faulty_o, stall_o, degraded_o); end
        do_reset();
        for (int n = 0; n < THR - 1; n++) step(1'b1, 4'b0100, 1'b1);
        vectors++; if (faulty_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL counters_cleared got %b exp 0000", faulty_o); end
    endtask

    task automatic test_random();
        bit         op;
        bit [3:0]   err;
        bit         idle;
        logic [3:0] e_clk;
        logic [2:0] e_sel;
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                op   = ($urandom_range(0, 3) != 0);
                err  = 4'($urandom) & 4'($urandom) & 4'($urandom);
                idle = ($urandom_range(0, 1) == 1);
                step(op, err, idle);
                e_clk = (m_mode == 1 && m_phase >= 1 && m_phase <= WC) ? 4'b1111 : ~(4'b0001 << m_off);
                for (int k = 0; k < 3; k++) e_sel[k] = (m_off != k);
                vectors++; if (clock_en_o !== e_clk) begin miscompares++; $display("[TB] FAIL rnd_clock_en ep %0d cyc %0d got %b exp %b", ep, c, clock_en_o, e_clk); end
                vectors++; if (sel_mux_o !== e_sel) begin miscompares++; $display("[TB] FAIL rnd_sel_mux ep %0d cyc %0d got %b exp %b", ep, c, sel_mux_o, e_sel); end
                vectors++; if (stall_o !== (m_mode == 1)) begin miscompares++; $display("[TB] FAIL rnd_stall ep %0d cyc %0d got %b exp %b", ep, c, stall_o, (m_mode == 1)); end
                vectors++; if (faulty_o !== m_faulty) begin miscompares++; $display("[TB] FAIL rnd_faulty ep %0d cyc %0d got %b exp %b", ep, c, faulty_o, m_faulty); end
                vectors++; if (fault_event_o !== m_event) begin miscompares++; $display("[TB] FAIL rnd_event ep %0d cyc %0d got %b exp %b", ep, c, fault_event_o, m_event); end
                vectors++; if (degraded_o !== (m_mode == 2)) begin miscompares++; $display("[TB] FAIL rnd_degraded ep %0d cyc %0d got %b exp %b", ep, c, degraded_o, (m_mode == 2)); end
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        op_valid_i     = 1'b0;
        err_detected_i = 4'b0000;
        ex_idle_i      = 1'b0;
        $display("[TB] starting");
        test_reset();
        test_single_fault();
        test_second_fault();
        test_spare_ignored();
        test_decay();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
